audio_sample_buffer: RTL and testbench
======================================

Name: audio_sample_buffer

Overview:
Downstream consumer of the data-acquisition FSM's audio stream, in the CLK_40 domain. Packs the serial received_bit stream into 8-bit PCM samples while audio_data_ready is high and buffers them in a FIFO. Pops one sample per 8 kHz tick, derived from CLK_40, and drives a 1-bit PWM audio output. Also reports FIFO status back to the mode/data FSMs so they can request more audio.

Parameters:
DATA_W, 8, sample width in bits
DEPTH, 256, FIFO depth in samples (power of two); ADDR_W = $clog2(DEPTH)
TICK_DIV, 5000, CLK_40 cycles per sample period (40 MHz / 8 kHz)
LOW_WATER, 64, req_more asserts while level < LOW_WATER
IDLE_SAMPLE, 8'h80, value output on underrun or while stopped (midscale)

Ports:
CLK_40  in  1  system clock, 40 MHz
reset  in  1  asynchronous, active-high reset
data_clk_rising_edge  in  1  one-cycle strobe; a valid bit is present on received_bit
audio_data_ready  in  1  qualifies the bit strobes as audio payload
received_bit  in  1  serial data, MSB first
play_en  in  1  playback enable; low = paused
sample_out  out  DATA_W  current sample
sample_valid  out  1  one-cycle pulse when sample_out updates
audio_pwm  out  1  PWM audio output
fifo_level  out  ADDR_W+1  number of stored samples
fifo_full  out  1  level == DEPTH
fifo_empty  out  1  level == 0
req_more  out  1  level < LOW_WATER
overflow  out  1  sticky; a packed sample was dropped
underrun_cnt  out  16  saturating count of ticks that found the FIFO empty

Behaviour:
- Reset is asynchronous. All of the following are restored on reset:
  - FIFO pointers and level = 0; shift register = 0; bit counter = 0.
  - Tick counter = 0; PWM counter = 0.
  - sample_out = IDLE_SAMPLE; sample_valid = 0; overflow = 0; underrun_cnt = 0.
  - Reset mid-byte or mid-playback discards all buffered data.
- Deserializer:
  - On data_clk_rising_edge && audio_data_ready: shift = {shift[6:0], received_bit}; bit_cnt += 1.
  - On the 8th bit (bit_cnt == 7), issue a write of {shift[6:0], received_bit} in that cycle; bit_cnt wraps to 0.
  - If audio_data_ready is low in any cycle, bit_cnt clears to 0 and the partial byte is discarded.
- FIFO write:
  - Accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped and overflow is set (sticky until reset).
  - fifo_level reflects the write on the next cycle.
- Tick generator:
  - While play_en = 1: count 0..TICK_DIV-1; tick = (count == TICK_DIV-1); wrap to 0.
  - While play_en = 0: count is held at 0, no ticks, and sample_out holds its last value.
  - The first tick after play_en rises comes TICK_DIV cycles later.
- Pop on tick:
  - FIFO not empty: read the head. Next cycle, sample_out = head and sample_valid = 1 for one cycle.
  - FIFO empty: next cycle, sample_out = IDLE_SAMPLE, sample_valid = 1, and underrun_cnt increments, saturating at 16'hFFFF.
  - There is no write-to-read bypass: a write in the same cycle as a tick on an empty FIFO still underruns.
- Simultaneous write and pop: both happen and the level is unchanged. Pointers wrap modulo DEPTH.
- PWM:
  - 8-bit free-running counter pwm_cnt at CLK_40, giving a 156.25 kHz carrier.
  - audio_pwm is registered: audio_pwm <= (pwm_cnt < sample_out).
  - sample 0 gives a constant low output; 255 gives 255/256 duty.
- Status outputs:
  - fifo_full, fifo_empty and req_more are combinational from the level register.

Decomposition:
- Shared constants go in params.sv alongside the existing frame macros:
  - AUDIO_SAMPLE_RATE and the CLK_40 frequency, from which TICK_DIV is derived.
  - AUDIO_FIFO_DEPTH.
  - AUDIO_IDLE_SAMPLE.
- One sub-module: sync_fifo (parameterised DATA_W/DEPTH; wr_en, rd_en, rd_data registered, level/full/empty). It is reusable for a later video line buffer.
- The deserializer, tick generator and PWM stay in audio_sample_buffer.

Test Plan:
- Reset, then shift bits 1,0,1,0,0,1,0,1 with audio_data_ready=1 -> fifo_level = 1 one cycle after the 8th strobe; with play_en=1, sample_out = 8'hA5 and sample_valid pulses 5000 cycles later.
- audio_data_ready drops after 5 bits, then 8 full bits 0xFF -> exactly one sample 0xFF is stored; the partial byte never appears.
- Write 257 samples with play_en=0 -> fifo_full = 1, level = 256, overflow = 1; the first 256 values play back in order after play_en=1.
- Empty FIFO with play_en=1 for 3 ticks -> sample_out = 8'h80 and underrun_cnt = 3; req_more = 1 throughout.
- Level = 256 and a byte completes in the same cycle as a tick -> the write is accepted, level stays 256, overflow stays 0.
- sample_out = 8'h40 -> audio_pwm is high for 64 of every 256 cycles; sample_out = 0 -> audio_pwm is never high; assert reset mid-PWM -> audio_pwm = 0 and sample_out = 8'h80 immediately (async).

Source files
------------

// File: rtl/audio_sample_buffer_pkg.sv
// Shared constants for the audio playback path: clock/sample-rate derived tick divider,
// FIFO sizing and the idle (midscale) sample value.
package audio_sample_buffer_pkg;

  localparam int unsigned CLK_40_HZ         = 40_000_000;
  localparam int unsigned AUDIO_SAMPLE_RATE = 8_000;
  localparam int unsigned AUDIO_TICK_DIV    = CLK_40_HZ / AUDIO_SAMPLE_RATE;
  localparam int unsigned AUDIO_DATA_W      = 8;
  localparam int unsigned AUDIO_FIFO_DEPTH  = 256;
  localparam int unsigned AUDIO_LOW_WATER   = 64;
  localparam logic [7:0]  AUDIO_IDLE_SAMPLE = 8'h80;

  // Saturating 16-bit increment for event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/audio_sample_buffer_sync_fifo.sv
// Single-clock FIFO with registered read data. A write into a full FIFO is still accepted
// when a read happens in the same cycle; otherwise it is dropped and flagged on wr_drop_o.
module audio_sample_buffer_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     wr_drop_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FullLvl = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_ok, wr_ok;

  assign full_o    = (level_q == FullLvl);
  assign empty_o   = (level_q == '0);
  assign rd_ok     = rd_en_i && !empty_o;
  assign wr_ok     = wr_en_i && (!full_o || rd_ok);
  assign wr_drop_o = wr_en_i && !wr_ok;
  assign level_o   = level_q;
  assign rd_data_o = rd_data_q;

  // Level tracks accepted writes minus reads; simultaneous write and read cancel.
  always_comb begin
    level_d = level_q;
    if (wr_ok && !rd_ok) begin
      level_d = level_q + (ADDR_W+1)'(1);
    end else if (!wr_ok && rd_ok) begin
      level_d = level_q - (ADDR_W+1)'(1);
    end
  end

  // Storage array; no reset needed since level gates every read.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers wrap modulo DEPTH; read data is captured before a same-cycle overwrite.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      level_q <= level_d;
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

endmodule

// File: rtl/audio_sample_buffer.sv
// Audio sample buffer: deserializes MSB-first payload bits into samples, buffers them,
// plays one sample per tick and drives a 1-bit PWM output plus FIFO status.
module audio_sample_buffer
  import audio_sample_buffer_pkg::*;
#(
  parameter int unsigned       DATA_W      = AUDIO_DATA_W,
  parameter int unsigned       DEPTH       = AUDIO_FIFO_DEPTH,
  parameter int unsigned       TICK_DIV    = AUDIO_TICK_DIV,
  parameter int unsigned       LOW_WATER   = AUDIO_LOW_WATER,
  parameter logic [DATA_W-1:0] IDLE_SAMPLE = DATA_W'(AUDIO_IDLE_SAMPLE)
) (
  input  logic                   CLK_40,
  input  logic                   reset,
  input  logic                   data_clk_rising_edge,
  input  logic                   audio_data_ready,
  input  logic                   received_bit,
  input  logic                   play_en,
  output logic [DATA_W-1:0]      sample_out,
  output logic                   sample_valid,
  output logic                   audio_pwm,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   req_more,
  output logic                   overflow,
  output logic [15:0]            underrun_cnt
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DATA_W);
  localparam int unsigned TICK_W = $clog2(TICK_DIV);

  logic [DATA_W-1:0] shift_q, shift_d, byte_data;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              byte_done;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick, rd_req, underrun;
  logic              show_fifo_q, show_fifo_d;
  logic              sample_valid_q, overflow_q, audio_pwm_q;
  logic [15:0]       underrun_q, underrun_d;
  logic [DATA_W-1:0] pwm_cnt_q;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [ADDR_W:0]   fifo_lvl;
  logic              fifo_full_w, fifo_empty_w, wr_drop;

  assign byte_data = {shift_q[DATA_W-2:0], received_bit};

  // Deserializer: any cycle without audio_data_ready discards the partial sample.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    byte_done = 1'b0;
    if (!audio_data_ready) begin
      bit_cnt_d = '0;
    end else if (data_clk_rising_edge) begin
      shift_d = byte_data;
      if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
        byte_done = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  // Sample-rate tick; counter parks at zero while paused so the first tick is a full period out.
  always_comb begin
    tick       = play_en && (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    tick_cnt_d = (!play_en || tick) ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Playback selection: a pop shows FIFO read data, an underrun shows the idle sample.
  always_comb begin
    rd_req      = tick && !fifo_empty_w;
    underrun    = tick && fifo_empty_w;
    show_fifo_d = show_fifo_q;
    if (rd_req) begin
      show_fifo_d = 1'b1;
    end else if (underrun) begin
      show_fifo_d = 1'b0;
    end
    underrun_d = underrun ? sat_inc16(underrun_q) : underrun_q;
  end

  audio_sample_buffer_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i     (CLK_40),
    .rst_i     (reset),
    .wr_en_i   (byte_done),
    .wr_data_i (byte_data),
    .rd_en_i   (rd_req),
    .rd_data_o (fifo_rd_data),
    .level_o   (fifo_lvl),
    .full_o    (fifo_full_w),
    .empty_o   (fifo_empty_w),
    .wr_drop_o (wr_drop)
  );

  // State registers for deserializer, tick, playback status and PWM.
  always_ff @(posedge CLK_40 or posedge reset) begin
    if (reset) begin
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      tick_cnt_q     <= '0;
      show_fifo_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      underrun_q     <= '0;
      pwm_cnt_q      <= '0;
      audio_pwm_q    <= 1'b0;
    end else begin
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      tick_cnt_q     <= tick_cnt_d;
      show_fifo_q    <= show_fifo_d;
      sample_valid_q <= tick;
      overflow_q     <= overflow_q | wr_drop;
      underrun_q     <= underrun_d;
      pwm_cnt_q      <= pwm_cnt_q + DATA_W'(1);
      audio_pwm_q    <= (pwm_cnt_q < sample_out);
    end
  end

  // sample_out is a pure function of registers, so reset forces the idle value at once.
  assign sample_out   = show_fifo_q ? fifo_rd_data : IDLE_SAMPLE;
  assign sample_valid = sample_valid_q;
  assign audio_pwm    = audio_pwm_q;
  assign fifo_level   = fifo_lvl;
  assign fifo_full    = fifo_full_w;
  assign fifo_empty   = fifo_empty_w;
  assign req_more     = (fifo_lvl < (ADDR_W+1)'(LOW_WATER));
  assign overflow     = overflow_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Scoreboard bench for audio_sample_buffer: a queue-level model predicts every played sample
// and the FIFO status; a monitor compares them against the DUT each cycle.
module tb_audio_sample_buffer;

  localparam int unsigned TICK_DIV  = 40;
  localparam int unsigned DEPTH     = 256;
  localparam int unsigned LOW_WATER = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       strobe = 1'b0;
  logic       ready = 1'b0;
  logic       rbit = 1'b0;
  logic       play_en = 1'b0;
  logic [7:0] sample_out;
  logic       sample_valid, audio_pwm, fifo_full, fifo_empty, req_more, overflow;
  logic [8:0] fifo_level;
  logic [15:0] underrun_cnt;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  // Reference model state.
  logic [7:0]  mq[$];
  logic [7:0]  exp_q[$];
  int          exp_rd = 0;
  logic [7:0]  part = 8'h00;
  int          nbits = 0;
  int          play_cycles = 0;
  bit          ovf_m = 1'b0;
  int unsigned und_m = 0;
  logic [7:0]  last_out = 8'h80;

  always #5 clk = ~clk;

  audio_sample_buffer #(
    .TICK_DIV (TICK_DIV)
  ) dut (
    .CLK_40               (clk),
    .reset                (reset),
    .data_clk_rising_edge (strobe),
    .audio_data_ready     (ready),
    .received_bit         (rbit),
    .play_en              (play_en),
    .sample_out           (sample_out),
    .sample_valid         (sample_valid),
    .audio_pwm            (audio_pwm),
    .fifo_level           (fifo_level),
    .fifo_full            (fifo_full),
    .fifo_empty           (fifo_empty),
    .req_more             (req_more),
    .overflow             (overflow),
    .underrun_cnt         (underrun_cnt)
  );

  // Model: a sample is the last 8 bits of an uninterrupted payload run; one pop per period.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      part = 8'h00;
      nbits = 0;
      play_cycles = 0;
      ovf_m = 1'b0;
      und_m = 0;
      last_out = 8'h80;
    end else begin
      bit tick_m;
      bit done_m;
      logic [7:0] byte_m;
      done_m = 1'b0;
      byte_m = 8'h00;
      if (!ready) begin
        nbits = 0;
      end else if (strobe) begin
        part = {part[6:0], rbit};
        nbits++;
        if (nbits == 8) begin
          done_m = 1'b1;
          byte_m = part;
          nbits = 0;
        end
      end
      if (play_en) begin
        play_cycles++;
        tick_m = (play_cycles % TICK_DIV) == 0;
      end else begin
        play_cycles = 0;
        tick_m = 1'b0;
      end
      if (tick_m) begin
        if (mq.size() > 0) begin
          last_out = mq.pop_front();
        end else begin
          last_out = 8'h80;
          if (und_m < 65535) und_m++;
        end
        exp_q.push_back(last_out);
      end
      if (done_m) begin
        if (mq.size() < DEPTH) mq.push_back(byte_m);
        else ovf_m = 1'b1;
      end
    end
  end

  // Monitor: scoreboard for played samples plus a per-cycle status comparison.
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      exp_rd = exp_q.size();
    end else if (armed) begin
      if (sample_valid || exp_rd < exp_q.size()) begin
        checks++;
        if (exp_rd >= exp_q.size()) begin
          errors++;
          $display("FAIL sample: unexpected sample_valid with sample_out=%02h, required no pulse",
                   sample_out);
        end else begin
          if (sample_valid !== 1'b1 || sample_out !== exp_q[exp_rd]) begin
            errors++;
            $display("FAIL sample #%0d: valid=%b out=%02h, required valid=1 out=%02h",
                     exp_rd, sample_valid, sample_out, exp_q[exp_rd]);
          end
          exp_rd++;
        end
      end
      checks++;
      if (fifo_level !== 9'(mq.size()) || fifo_full !== (mq.size() == DEPTH) ||
          fifo_empty !== (mq.size() == 0) || req_more !== (mq.size() < LOW_WATER) ||
          overflow !== ovf_m || underrun_cnt !== 16'(und_m)) begin
        errors++;
        $display("FAIL status: lvl=%0d full=%b empty=%b req=%b ovf=%b und=%0d, required lvl=%0d full=%b empty=%b req=%b ovf=%b und=%0d",
                 fifo_level, fifo_full, fifo_empty, req_more, overflow, underrun_cnt,
                 mq.size(), mq.size() == DEPTH, mq.size() == 0, mq.size() < LOW_WATER,
                 ovf_m, und_m);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    strobe = 1'b1;
    rbit = b;
    step(1);
    strobe = 1'b0;
    step($urandom_range(0, 2));
  endtask

  task automatic send_byte(input logic [7:0] b);
    ready = 1'b1;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic play_for(input int n);
    play_en = 1'b1;
    step(n * TICK_DIV);
    play_en = 1'b0;
    step(2);
  endtask

  // Reset is asserted between edges so the asynchronous response is observed directly.
  task automatic do_reset();
    #2;
    strobe = 1'b0;
    ready = 1'b0;
    play_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_sample_out", 32'(sample_out), 32'h80);
    chk("rst_audio_pwm", 32'(audio_pwm), 32'h0);
    chk("rst_sample_valid", 32'(sample_valid), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_empty", 32'(fifo_empty), 32'h1);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_underrun", 32'(underrun_cnt), 32'h0);
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    int cnt;
    int n;
    step(2);
    do_reset();
    armed = 1'b1;

    // Basic byte 1,0,1,0,0,1,0,1 then three underruns.
    send_byte(8'hA5);
    chk("level_after_byte", 32'(fifo_level), 32'd1);
    play_en = 1'b1;
    step(TICK_DIV + 2);
    chk("first_sample", 32'(sample_out), 32'hA5);
    step(3 * TICK_DIV);
    chk("underrun_cnt3", 32'(underrun_cnt), 32'd3);
    chk("idle_sample", 32'(sample_out), 32'h80);
    chk("req_more_low", 32'(req_more), 32'd1);
    play_en = 1'b0;
    step(2);

    // Partial byte aborted by audio_data_ready, then a full 0xFF.
    ready = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'(i % 2));
    ready = 1'b0;
    step(1);
    send_byte(8'hFF);
    chk("partial_dropped_level", 32'(fifo_level), 32'd1);
    play_for(2);

    // Overfill while paused, then play everything back in order.
    do_reset();
    for (int i = 0; i < 257; i++) send_byte(8'($urandom));
    chk("full_flag", 32'(fifo_full), 32'd1);
    chk("full_level", 32'(fifo_level), 32'd256);
    chk("overflow_set", 32'(overflow), 32'd1);
    play_for(259);

    // Write completing on the same edge as a pop from a full FIFO.
    do_reset();
    for (int i = 0; i < 256; i++) send_byte(8'($urandom));
    ready = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(1'($urandom));
    play_en = 1'b1;
    step(TICK_DIV - 1);
    strobe = 1'b1;
    rbit = 1'b1;
    step(1);
    strobe = 1'b0;
    chk("simul_level", 32'(fifo_level), 32'd256);
    chk("simul_overflow", 32'(overflow), 32'd0);
    play_en = 1'b0;
    step(2);

    // PWM duty for 0x40, 0x00 and a random nonzero sample, then reset mid-PWM.
    do_reset();
    r = 8'($urandom_range(1, 255));
    send_byte(8'h40);
    send_byte(8'h00);
    send_byte(r);
    for (int k = 0; k < 3; k++) begin
      play_for(1);
      cnt = 0;
      for (int i = 0; i < 256; i++) begin
        step(1);
        if (audio_pwm === 1'b1) cnt++;
      end
      chk("pwm_duty", 32'(cnt), 32'(last_out));
    end
    n = 0;
    while (audio_pwm !== 1'b1 && n < 300) begin
      step(1);
      n++;
    end
    chk("pwm_seen_high", 32'(n < 300), 32'd1);
    do_reset();

    // Random bit stream with payload drops and play toggling.
    ready = 1'b1;
    for (int i = 0; i < 320; i++) begin
      if (i % 64 == 0) play_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        ready = 1'b0;
        step(1);
        ready = 1'b1;
      end
      send_bit(1'($urandom));
    end
    play_for(8);

    chk("scoreboard_drained", 32'(exp_rd), 32'(exp_q.size()));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
